// File: rtl/at_hazard_unit_pkg.sv
// Shared record type and helpers for the Tuse/Tnew hazard tracker.
// Optional MDU busy tracking is enabled elsewhere with AT_MDU_BUSY_EN.
package at_pkg;

   localparam int AT_AW = 5;
   localparam int AT_DW = 32;
   localparam int AT_TW = 2;

   // One in-flight destination: which register, cycles until ready, value if ready.
   typedef struct packed {
      logic [AT_AW-1:0] addr;
      logic [AT_TW-1:0] tnew;
      logic [AT_DW-1:0] val;
   } rec_t;

   function automatic logic [AT_TW-1:0] sat_dec(input logic [AT_TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/at_hazard_unit_if.sv
// Decode-side hazard bus between the pipeline (master) and the hazard unit (slave).
// AT_MDU_BUSY_EN adds the multiply/divide busy handshake signals.
interface at_hazard_unit_if
   import at_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int NRD    = 2,
   parameter int AW     = AT_AW,
   parameter int DW     = AT_DW,
   parameter int TW     = AT_TW
);
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*TW-1:0]    rd_tuse;
   logic [NRD*DW-1:0]    rd_grf;
   logic [AW-1:0]        wr_addr;
   logic [TW-1:0]        wr_tnew;
   logic [DW-1:0]        wr_val;
   logic [NSTAGE-1:0]    st_res_vld;
   logic [NSTAGE*DW-1:0] st_res;
   logic                 stall;
   logic [NRD*DW-1:0]    rd_fwd;
   logic [31:0]          stall_cnt;
`ifdef AT_MDU_BUSY_EN
   logic                 md_start;
   logic [3:0]           md_lat;
   logic                 md_use;
`endif

   modport master (
`ifdef AT_MDU_BUSY_EN
      output md_start, md_lat, md_use,
`endif
      output rd_addr, rd_tuse, rd_grf, wr_addr, wr_tnew, wr_val, st_res_vld, st_res,
      input  stall, rd_fwd, stall_cnt
   );

   modport slave (
`ifdef AT_MDU_BUSY_EN
      input  md_start, md_lat, md_use,
`endif
      input  rd_addr, rd_tuse, rd_grf, wr_addr, wr_tnew, wr_val, st_res_vld, st_res,
      output stall, rd_fwd, stall_cnt
   );

endinterface

// File: rtl/at_hazard_unit_match.sv
// Per-read-port priority search over the stage records (youngest stage wins).
module at_match #(
   parameter int NSTAGE = 3,
   parameter int AW     = 5,
   parameter int DW     = 32,
   parameter int TW     = 2,
   parameter int IW     = 2
) (
   input  logic [AW-1:0]        rdAddr,
   input  logic [TW-1:0]        rdTuse,
   input  logic [DW-1:0]        rdGrf,
   input  logic [NSTAGE*AW-1:0] recAddr,
   input  logic [NSTAGE*TW-1:0] recTnew,
   input  logic [NSTAGE*DW-1:0] effVal,
   output logic                 hit,
   output logic [IW-1:0]        hitIdx,
   output logic                 stallP,
   output logic [DW-1:0]        fwdVal
);

   always_comb begin
      hit    = 1'b0;
      hitIdx = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (rdAddr != '0 && recAddr[k*AW +: AW] == rdAddr) begin
            hit    = 1'b1;
            hitIdx = IW'(k);
         end
      end
      fwdVal = hit ? effVal[hitIdx*DW +: DW] : rdGrf;
      stallP = hit && (rdTuse < recTnew[hitIdx*TW +: TW]);
   end

endmodule

// File: rtl/at_hazard_unit.sv
// Tuse/Tnew hazard tracker and operand forwarding beside the decode stage.
// Define AT_MDU_BUSY_EN to add the MDU busy counter and its stall term.
module at_hazard_unit
   import at_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int NRD    = 2,
   parameter int AW     = AT_AW,
   parameter int DW     = AT_DW,
   parameter int TW     = AT_TW
) (
   input logic        clk,
   input logic        reset_n,
   at_hazard_unit_if.slave hz
);

   localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   rec_t                 rec_reg [NSTAGE];
   logic [31:0]          stallCnt_reg;
   logic [NSTAGE*AW-1:0] recAddr;
   logic [NSTAGE*TW-1:0] recTnew;
   logic [NSTAGE*DW-1:0] effVal;
   logic [NRD-1:0]       hit;
   logic [NRD-1:0]       stallP;
   logic [IW-1:0]        hitIdx [NRD];
   logic [DW-1:0]        fwdVal [NRD];
   logic [NRD*DW-1:0]    rdFwd;
   logic                 stall;

   generate
      for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
         assign recAddr[gi*AW +: AW] = rec_reg[gi].addr;
         assign recTnew[gi*TW +: TW] = rec_reg[gi].tnew;
         // A result produced this cycle beats the stored value, both for forwarding and the next hop.
         assign effVal[gi*DW +: DW]  = hz.st_res_vld[gi] ? hz.st_res[gi*DW +: DW] : rec_reg[gi].val;
      end

      for (genvar gi = 0; gi < NRD; gi++) begin : g_port
         at_match #(
            .NSTAGE(NSTAGE), .AW(AW), .DW(DW), .TW(TW), .IW(IW)
         ) u_match (
            .rdAddr (hz.rd_addr[gi*AW +: AW]),
            .rdTuse (hz.rd_tuse[gi*TW +: TW]),
            .rdGrf  (hz.rd_grf[gi*DW +: DW]),
            .recAddr(recAddr),
            .recTnew(recTnew),
            .effVal (effVal),
            .hit    (hit[gi]),
            .hitIdx (hitIdx[gi]),
            .stallP (stallP[gi]),
            .fwdVal (fwdVal[gi])
         );
         assign rdFwd[gi*DW +: DW] = (hit[gi] && recTnew[hitIdx[gi]*TW +: TW] == '0)
                                     ? fwdVal[gi] : hz.rd_grf[gi*DW +: DW];
      end
   endgenerate

`ifdef AT_MDU_BUSY_EN
   logic [3:0] mdCnt_reg;
   logic       mdBusy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mdCnt_reg <= '0;
      end else if (hz.md_start) begin
         mdCnt_reg <= hz.md_lat;
      end else if (mdCnt_reg != '0) begin
         mdCnt_reg <= mdCnt_reg - 4'd1;
      end
   end

   assign mdBusy = (mdCnt_reg != '0) || hz.md_start;
   assign stall  = (|stallP) || (hz.md_use && mdBusy);
`else
   assign stall  = |stallP;
`endif

   // Only the decode entry takes the bubble; the post-decode records always advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NSTAGE; k++) begin
            rec_reg[k] <= '0;
         end
         stallCnt_reg <= '0;
      end else begin
         if (stall) begin
            rec_reg[0] <= '0;
         end else begin
            rec_reg[0] <= '{addr: hz.wr_addr, tnew: hz.wr_tnew, val: hz.wr_val};
         end
         for (int k = 1; k < NSTAGE; k++) begin
            rec_reg[k] <= '{addr: rec_reg[k-1].addr,
                            tnew: sat_dec(rec_reg[k-1].tnew),
                            val:  effVal[(k-1)*DW +: DW]};
         end
         if (stall && stallCnt_reg != 32'hFFFF_FFFF) begin
            stallCnt_reg <= stallCnt_reg + 32'd1;
         end
      end
   end

   assign hz.stall     = stall;
   assign hz.rd_fwd    = rdFwd;
   assign hz.stall_cnt = stallCnt_reg;

endmodule
